reg_bank: RTL and testbench

// - Parametrised multi-register bank for the datapath; generalises the single load/hold temp register.
// - Holds DEPTH words of WIDTH bits, with one write port and two independent read ports (A, B).
// - Read outputs are registered and hold their value when not enabled, like the temp register.
// - Adds a write-first bypass, a synchronous clear-all and a per-entry written flag.
// - Sits between the control unit (addresses, enables) and the ALU operand inputs.

---
 rtl/pcid_pkg.sv | 6 +
 rtl/reg_bank_if.sv | 26 ++
 rtl/reg_bank_rport.sv | 29 ++
 rtl/reg_bank.sv | 52 +++++
 tb/tb_reg_bank.sv | 120 ++++++++++++
 5 files changed

// File: rtl/pcid_pkg.sv
// pcid_pkg: shared datapath widths and the register-bank address type
package pcid_pkg;
  localparam int DATA_W = 16;
  localparam int REG_DEPTH = 8;
  typedef logic [$clog2(REG_DEPTH)-1:0] reg_addr_t;
endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: control-unit to register-bank bus with one write port and two read ports
interface reg_bank_if import pcid_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = REG_DEPTH
);
  localparam int AW = $clog2(DEPTH);
  logic             clr;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             re_a;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic             re_b;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic [DEPTH-1:0] written;
  modport master (
    output clr, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rdata_b, written
  );
  modport slave (
    input  clr, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rdata_b, written
  );
endinterface

// File: rtl/reg_bank_rport.sv
// reg_bank_rport: one registered read port with range check, write-first bypass and hold
module reg_bank_rport import pcid_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = REG_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_clr,
  input  logic                        i_we,
  input  logic [AW-1:0]               i_waddr,
  input  logic [WIDTH-1:0]            i_wdata,
  input  logic [DEPTH-1:0][WIDTH-1:0] i_entries,
  input  logic                        i_re,
  input  logic [AW-1:0]               i_raddr,
  output logic [WIDTH-1:0]            o_rdata
);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
  logic             w_rin;
  logic             w_byp;
  logic [WIDTH-1:0] w_next;
  assign w_rin  = {1'b0, i_raddr} < LIM;
  // an in-range read address matching the write address implies the write is in range too
  assign w_byp  = i_we && w_rin && (i_raddr == i_waddr);
  assign w_next = i_clr ? '0 : w_byp ? i_wdata : w_rin ? i_entries[i_raddr] : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) o_rdata <= '0;
    else if (i_re) o_rdata <= w_next;
endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank with clear-all, written flags and two read ports
module reg_bank import pcid_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = REG_DEPTH
) (
  input logic      clk,
  input logic      reset,
  reg_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            r_written;
  logic                        w_wen;
  assign w_wen = bus.we && ({1'b0, bus.waddr} < LIM);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_mem     <= '0;
      r_written <= '0;
    end else if (bus.clr) begin
      r_mem     <= '0;
      r_written <= '0;
    end else if (w_wen) begin
      r_mem[bus.waddr]     <= bus.wdata;
      r_written[bus.waddr] <= 1'b1;
    end
  assign bus.written = r_written;
  reg_bank_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rport_a (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (bus.clr),
    .i_we      (bus.we),
    .i_waddr   (bus.waddr),
    .i_wdata   (bus.wdata),
    .i_entries (r_mem),
    .i_re      (bus.re_a),
    .i_raddr   (bus.raddr_a),
    .o_rdata   (bus.rdata_a)
  );
  reg_bank_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rport_b (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (bus.clr),
    .i_we      (bus.we),
    .i_waddr   (bus.waddr),
    .i_wdata   (bus.wdata),
    .i_entries (r_mem),
    .i_re      (bus.re_b),
    .i_raddr   (bus.raddr_b),
    .o_rdata   (bus.rdata_b)
  );
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: table-driven check of reg_bank (DEPTH=8) plus a DEPTH=6 out-of-range sequence
module tb_reg_bank;
  typedef struct {
    logic        clr;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        re_a;
    logic [2:0]  ra;
    logic        re_b;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [7:0]  ew;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[25];
  reg_bank_if #(.WIDTH(16), .DEPTH(8)) b8 ();
  reg_bank_if #(.WIDTH(16), .DEPTH(6)) b6 ();
  reg_bank #(.WIDTH(16), .DEPTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  reg_bank #(.WIDTH(16), .DEPTH(6)) dut6 (.clk(clk), .reset(reset), .bus(b6));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle8();
    b8.clr = 1'b0; b8.we = 1'b0; b8.waddr = '0; b8.wdata = '0;
    b8.re_a = 1'b0; b8.raddr_a = '0; b8.re_b = 1'b0; b8.raddr_b = '0;
  endtask
  task automatic idle6();
    b6.clr = 1'b0; b6.we = 1'b0; b6.waddr = '0; b6.wdata = '0;
    b6.re_a = 1'b0; b6.raddr_a = '0; b6.re_b = 1'b0; b6.raddr_b = '0;
  endtask
  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b0, 1'b0, '0, '0, 1'b1, 3'(i), 1'b0, '0, '0, '0, '0};
    tbl[8]  = '{1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, '0, 1'b0, '0, 16'h0000, 16'h0000, 8'h08};
    tbl[9]  = '{1'b0, 1'b0, '0, '0, 1'b1, 3'd3, 1'b0, '0, 16'hBEEF, 16'h0000, 8'h08};
    tbl[10] = '{1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd3, 16'hBEEF, 16'hBEEF, 8'h08};
    tbl[11] = '{1'b0, 1'b1, 3'd5, 16'h1111, 1'b0, '0, 1'b0, '0, 16'hBEEF, 16'hBEEF, 8'h28};
    tbl[12] = '{1'b0, 1'b1, 3'd5, 16'h2222, 1'b1, 3'd5, 1'b1, 3'd5, 16'h2222, 16'h2222, 8'h28};
    tbl[13] = '{1'b0, 1'b0, '0, '0, 1'b1, 3'd5, 1'b0, '0, 16'h2222, 16'h2222, 8'h28};
    tbl[14] = '{1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 3'd3, 16'h2222, 16'hBEEF, 8'h28};
    for (int i = 15; i < 19; i++)
      tbl[i] = '{1'b0, 1'b1, 3'd3, 16'h0001, 1'b0, '0, 1'b0, '0, 16'h2222, 16'hBEEF, 8'h28};
    tbl[19] = '{1'b0, 1'b0, '0, '0, 1'b1, 3'd3, 1'b0, '0, 16'h0001, 16'hBEEF, 8'h28};
    tbl[20] = '{1'b0, 1'b1, 3'd0, 16'h1234, 1'b0, '0, 1'b1, 3'd0, 16'h0001, 16'h1234, 8'h29};
    tbl[21] = '{1'b1, 1'b1, 3'd2, 16'h00FF, 1'b1, 3'd2, 1'b0, '0, 16'h0000, 16'h1234, 8'h00};
    tbl[22] = '{1'b0, 1'b0, '0, '0, 1'b1, 3'd3, 1'b1, 3'd2, 16'h0000, 16'h0000, 8'h00};
    tbl[23] = '{1'b0, 1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd7, 1'b1, 3'd6, 16'hFFFF, 16'h0000, 8'h80};
    tbl[24] = '{1'b0, 1'b0, '0, '0, 1'b1, 3'd7, 1'b1, 3'd7, 16'hFFFF, 16'hFFFF, 8'h80};
    idle8();
    idle6();
    #12;
    chk("rst_a", 32'(b8.rdata_a), 32'h0);
    chk("rst_b", 32'(b8.rdata_b), 32'h0);
    chk("rst_w", 32'(b8.written), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    // load state, then wipe it with a reset pulse landing between edges
    @(negedge clk);
    b8.we = 1'b1; b8.waddr = 3'd1; b8.wdata = 16'hAAAA; b8.re_a = 1'b1; b8.raddr_a = 3'd1;
    @(posedge clk); #1;
    chk("pre_a", 32'(b8.rdata_a), 32'hAAAA);
    chk("pre_w", 32'(b8.written), 32'h02);
    idle8();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_a", 32'(b8.rdata_a), 32'h0);
    chk("mid_rst_w", 32'(b8.written), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      b8.clr = tbl[i].clr; b8.we = tbl[i].we; b8.waddr = tbl[i].waddr; b8.wdata = tbl[i].wdata;
      b8.re_a = tbl[i].re_a; b8.raddr_a = tbl[i].ra; b8.re_b = tbl[i].re_b; b8.raddr_b = tbl[i].rb;
      @(posedge clk); #1;
      chk($sformatf("v%0d_a", i), 32'(b8.rdata_a), 32'(tbl[i].ea));
      chk($sformatf("v%0d_b", i), 32'(b8.rdata_b), 32'(tbl[i].eb));
      chk($sformatf("v%0d_w", i), 32'(b8.written), 32'(tbl[i].ew));
    end
    idle8();
    @(negedge clk);
    b6.we = 1'b1; b6.waddr = 3'd1; b6.wdata = 16'h5555;
    @(posedge clk); #1;
    chk("d6_wr_w", 32'(b6.written), 32'h02);
    @(negedge clk);
    b6.waddr = 3'd7; b6.wdata = 16'h9999; b6.re_a = 1'b1; b6.raddr_a = 3'd1;
    @(posedge clk); #1;
    chk("d6_drop_a", 32'(b6.rdata_a), 32'h5555);
    chk("d6_drop_w", 32'(b6.written), 32'h02);
    @(negedge clk);
    b6.raddr_a = 3'd7;
    @(posedge clk); #1;
    chk("d6_oor7_a", 32'(b6.rdata_a), 32'h0);
    chk("d6_oor7_w", 32'(b6.written), 32'h02);
    @(negedge clk);
    b6.waddr = 3'd6; b6.wdata = 16'h7777; b6.raddr_a = 3'd1; b6.re_b = 1'b1; b6.raddr_b = 3'd6;
    @(posedge clk); #1;
    chk("d6_keep_a", 32'(b6.rdata_a), 32'h5555);
    chk("d6_nobyp_b", 32'(b6.rdata_b), 32'h0);
    chk("d6_drop6_w", 32'(b6.written), 32'h02);
    @(negedge clk);
    b6.we = 1'b0; b6.raddr_a = 3'd6; b6.raddr_b = 3'd5;
    @(posedge clk); #1;
    chk("d6_oor6_a", 32'(b6.rdata_a), 32'h0);
    chk("d6_e5_b", 32'(b6.rdata_b), 32'h0);
    chk("d6_end_w", 32'(b6.written), 32'h02);
    idle6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
